// File: rtl/reg_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_share_arbiter
//  Description : Round-robin arbiter and write sequencer that shares one
//                W-bit register between N requesters. Each grant lasts up to
//                MAX_HOLD cycles and is followed by a one-cycle turnaround.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_share_arbiter #(
    parameter int             N         = 4,
    parameter int             W         = 8,
    parameter int             MAX_HOLD  = 4,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N-1:0]                       req,
    input  logic [N-1:0]                       we,
    input  logic [N*W-1:0]                     wdata,
    output logic [N-1:0]                       gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner_id,
    output logic                               busy,
    output logic [W-1:0]                       q
);

    localparam int c_id_w   = (N > 1) ? $clog2(N) : 1;
    localparam int c_hold_w = $clog2(MAX_HOLD + 1);

    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD);
    localparam logic [c_id_w-1:0]   c_last_rst = c_id_w'(N - 1);
    localparam logic [c_id_w:0]     c_n_ext    = (c_id_w + 1)'(N);
    localparam logic [N-1:0]        c_gnt_one  = N'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Registered state
    state_t                r_state;
    logic [N-1:0]          r_gnt;
    logic                  r_busy;
    logic [c_id_w-1:0]     r_owner;
    logic [c_id_w-1:0]     r_last;
    logic [c_hold_w-1:0]   r_hold;
    logic [W-1:0]          r_q;

    // Next-state values
    state_t                w_state_nxt;
    logic [N-1:0]          w_gnt_nxt;
    logic                  w_busy_nxt;
    logic [c_id_w-1:0]     w_owner_nxt;
    logic [c_id_w-1:0]     w_last_nxt;
    logic [c_hold_w-1:0]   w_hold_nxt;
    logic [W-1:0]          w_q_nxt;

    // Arbitration results
    logic                  w_pick_found;
    logic [c_id_w-1:0]     w_pick;
    logic [c_id_w:0]       w_cand;

    // Per-requester view of the packed write data
    logic [W-1:0]          w_wdata_arr [N];
    logic [W-1:0]          w_owner_wdata;
    logic                  w_owner_we;
    logic                  w_owner_req;

    generate
        for (genvar i = 0; i < N; i++) begin : g_unpack
            assign w_wdata_arr[i] = wdata[i*W +: W];
        end
    endgenerate

    // Only the current owner's controls ever reach the register.
    assign w_owner_wdata = w_wdata_arr[r_owner];
    assign w_owner_we    = we[r_owner];
    assign w_owner_req   = req[r_owner];

    // Round-robin search starting one past the previous owner, with wrap.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = '0;
        w_cand       = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = {1'b0, r_last} + (c_id_w + 1)'(k);
            if (w_cand >= c_n_ext) begin
                w_cand = w_cand - c_n_ext;
            end
            if (!w_pick_found && req[w_cand[c_id_w-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick       = w_cand[c_id_w-1:0];
            end
        end
    end

    // Next-state, grant and register-write decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_q_nxt     = r_q;

        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = S_OWN;
                    w_gnt_nxt   = c_gnt_one << w_pick;
                    w_busy_nxt  = 1'b1;
                    w_owner_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    w_hold_nxt  = c_hold_one;
                end
            end

            S_OWN: begin
                // The owner may write in every OWN cycle, including the last.
                if (w_owner_we) begin
                    w_q_nxt = w_owner_wdata;
                end
                if (!w_owner_req || (r_hold == c_hold_max)) begin
                    w_state_nxt = S_RELEASE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold + c_hold_one;
                end
            end

            S_RELEASE: begin
                // Turnaround cycle: no grant can be issued here.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, pointer, hold counter and shared register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_last  <= c_last_rst;
            r_hold  <= '0;
            r_q     <= RESET_VAL;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            r_q     <= w_q_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign busy     = r_busy;
    assign owner_id = r_owner;
    assign q        = r_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_share_arbiter
//  Description : Scoreboard bench for reg_share_arbiter. A behavioural model
//                predicts the post-edge outputs for every driven cycle; a
//                separate monitor compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_share_arbiter;

    localparam int           N        = 4;
    localparam int           W        = 8;
    localparam int           MAX_HOLD = 4;
    localparam int           OW       = 2;
    localparam logic [W-1:0] RST_V    = 8'h5C;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*W-1:0]  wdata;
    logic [N-1:0]    gnt;
    logic [OW-1:0]   owner_id;
    logic            busy;
    logic [W-1:0]    q;

    reg_share_arbiter #(
        .N         (N),
        .W         (W),
        .MAX_HOLD  (MAX_HOLD),
        .RESET_VAL (RST_V)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .wdata    (wdata),
        .gnt      (gnt),
        .owner_id (owner_id),
        .busy     (busy),
        .q        (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic [N-1:0]   gnt;
        logic           busy;
        logic [OW-1:0]  own;
        logic [W-1:0]   q;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: who owns the register, for how long, and the gap.
    int           m_owner;
    int           m_held;
    int           m_gap;
    int           m_last;
    logic [W-1:0] m_q;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] d3, input logic [W-1:0] d2,
                                            input logic [W-1:0] d1, input logic [W-1:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_last  = N - 1;
        m_q     = RST_V;
    endtask

    // Called at posedge+2: apply inputs, predict the next edge, advance.
    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N*W-1:0] d);
        exp_t e;
        req   = r;
        we    = w;
        wdata = d;
        if (m_owner >= 0) begin
            if (w[m_owner]) m_q = d[m_owner*W +: W];
            if (!r[m_owner] || m_held == MAX_HOLD) begin
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else if (r != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && r[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_last  = m_owner;
                    m_held  = 1;
                end
            end
        end
        e.cyc  = cyc + 1;
        e.busy = (m_owner >= 0);
        e.gnt  = e.busy ? (N'(1) << m_owner) : '0;
        e.own  = e.busy ? OW'(m_owner) : '0;
        e.q    = m_q;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2: assert reset mid-period, check it acts at once,
    // then release it at the following posedge+2.
    task automatic reset_mid();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_gnt",   32'(gnt),      32'(0));
        chk("rst_busy",  32'(busy),     32'(0));
        chk("rst_q",     32'(q),        32'(RST_V));
        chk("rst_owner", 32'(owner_id), 32'(0));
        sb.delete();
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: compare each cycle's outputs against the scoreboard entry.
    int busy_run = 0;
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0) begin
                if (sb[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_entry actual_cycle=%0d required_cycle=%0d", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end else if (sb[0].cyc == cyc) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("gnt",  32'(gnt),  32'(e.gnt));
                    chk("busy", 32'(busy), 32'(e.busy));
                    chk("q",    32'(q),    32'(e.q));
                    if (e.busy) chk("owner_id", 32'(owner_id), 32'(e.own));
                end
            end
            if (busy) begin
                busy_run++;
            end else begin
                if (busy_run > 0) begin
                    checks++;
                    if (busy_run > MAX_HOLD) begin
                        errors++;
                        $display("FAIL busy_run actual=%0d required_max=%0d", busy_run, MAX_HOLD);
                    end
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] rq;
        reset = 1'b0;
        req   = '0;
        we    = '0;
        wdata = '0;
        model_reset();
        @(posedge clk);
        #2;
        // Reset values and release with no request
        reset_mid();
        repeat (3) drive('0, '0, '0);

        // Single requester write
        drive(4'b0001, 4'b0001, pack(8'h00, 8'h00, 8'h00, 8'hA5));
        drive(4'b0001, 4'b0001, pack(8'h00, 8'h00, 8'h00, 8'hA5));
        repeat (4) drive('0, '0, '0);

        // Round-robin with all requesters active
        repeat (26) drive(4'b1111, 4'b1111, pack(8'h04, 8'h03, 8'h02, 8'h01));
        repeat (3) drive('0, '0, '0);

        // Non-owner writes are masked, then owner write
        repeat (3) drive(4'b0010, 4'b0101, pack(8'h00, 8'h22, 8'h00, 8'h11));
        drive(4'b0010, 4'b0010, pack(8'h00, 8'h00, 8'h33, 8'h00));
        repeat (3) drive('0, '0, '0);

        // Forced release with one requester holding req
        repeat (14) drive(4'b0100, N'($urandom), (N*W)'({$urandom, $urandom}));
        repeat (3) drive('0, '0, '0);

        // Reset during the second OWN cycle of requester 3
        reset_mid();
        drive(4'b1000, 4'b1000, pack(8'h77, 8'h00, 8'h00, 8'h00));
        drive(4'b1000, 4'b1000, pack(8'h77, 8'h00, 8'h00, 8'h00));
        we    = 4'b1000;
        wdata = pack(8'h5A, 8'h00, 8'h00, 8'h00);
        reset_mid();
        drive(4'b1000, '0, '0);
        chk("regrant_gnt",   32'(gnt),      32'(4'b1000));
        chk("regrant_owner", 32'(owner_id), 32'(3));
        repeat (6) drive('0, '0, '0);

        // Randomized traffic with persistent request lines
        rq = '0;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            if (i == 400) reset_mid();
            drive(rq, N'($urandom), (N*W)'({$urandom, $urandom}));
        end
        repeat (4) drive('0, '0, '0);

        @(posedge clk);
        #4;
        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
